// File: rtl/chirp_cfg_pkg.sv
// Shared widths, configuration record and handshake FSM states for the
// chirp configuration transfer into the DDS domain.
package chirp_cfg_pkg;

  localparam int FREQ_W = 48;
  localparam int RATE_W = 32;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] dfreq;
    logic [RATE_W-1:0] rate;
  } chirp_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK_HI,
    WAIT_ACK_LO
  } cfg_tx_state_t;

endpackage

// File: rtl/chirp_cfg_tx.sv
// Source-side 4-phase REQ/ACK initiator with a one-deep pending buffer.
// Optional per-phase timeout abort is enabled with `define CFG_TIMEOUT_EN.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   IDLE        | no transfer; launches on load or queued entry
//   WAIT_ACK_HI | REQ high, buses held, waiting for ACK to rise
//   WAIT_ACK_LO | REQ low, buses held, waiting for ACK to fall
module chirp_cfg_tx
  import chirp_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_125,
  input  logic              reset_n,
  input  logic              load,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic [FREQ_W-1:0] dfreq_in,
  input  logic [RATE_W-1:0] rate_in,
  output logic              REQ,
  input  logic              ACK,
  output logic [FREQ_W-1:0] DDS_freq,
  output logic [FREQ_W-1:0] DDS_delta_freq,
  output logic [RATE_W-1:0] DDS_delta_rate,
  output logic              busy,
  output logic              pending,
  output logic              done,
  output logic              overrun,
  output logic              err
);

  cfg_tx_state_t state;
  chirp_cfg_t    cfg_in;
  chirp_cfg_t    cfg_q;
  chirp_cfg_t    pend_q;
  logic          req_q;
  logic          busy_q;
  logic          pend_vld;
  logic          done_q;
  logic          ovr_q;

  assign cfg_in = '{freq: freq_in, dfreq: dfreq_in, rate: rate_in};

`ifdef CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             err_q;
  logic             abort_q;

  // Fires on the edge where the phase counter would reach TIMEOUT_CYC.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;
`else
  // Timeout logic is absent; the parameter stays for a uniform interface.
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cfg_q    <= '0;
      pend_q   <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      pend_vld <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef CFG_TIMEOUT_EN
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef CFG_TIMEOUT_EN
      err_q   <= 1'b0;
      tmo_cnt <= (state == IDLE) ? '0 : tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (load) begin
            cfg_q    <= cfg_in;
            ovr_q    <= pend_vld;
            pend_vld <= 1'b0;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            state    <= WAIT_ACK_HI;
`ifdef CFG_TIMEOUT_EN
            abort_q  <= 1'b0;
`endif
          end else if (pend_vld) begin
            cfg_q    <= pend_q;
            pend_vld <= 1'b0;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            state    <= WAIT_ACK_HI;
`ifdef CFG_TIMEOUT_EN
            abort_q  <= 1'b0;
`endif
          end
        end
        WAIT_ACK_HI: begin
          if (ACK) begin
            req_q <= 1'b0;
            state <= WAIT_ACK_LO;
`ifdef CFG_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            // Abort: drop REQ and still let the receiver settle ACK low.
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            req_q   <= 1'b0;
            state   <= WAIT_ACK_LO;
            tmo_cnt <= '0;
`endif
          end
        end
        WAIT_ACK_LO: begin
          if (!ACK) begin
`ifdef CFG_TIMEOUT_EN
            done_q  <= !abort_q;
            tmo_cnt <= '0;
`else
            done_q  <= 1'b1;
`endif
            busy_q <= 1'b0;
            state  <= IDLE;
`ifdef CFG_TIMEOUT_EN
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
            tmo_cnt <= '0;
`endif
          end
        end
        default: begin
          req_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // Writes during a transfer (including its completing edge) are queued.
      if (load && (state != IDLE)) begin
        pend_q   <= cfg_in;
        pend_vld <= 1'b1;
        ovr_q    <= pend_vld;
      end
    end
  end

  assign REQ            = req_q;
  assign busy           = busy_q;
  assign pending        = pend_vld;
  assign done           = done_q;
  assign overrun        = ovr_q;
  assign DDS_freq       = cfg_q.freq;
  assign DDS_delta_freq = cfg_q.dfreq;
  assign DDS_delta_rate = cfg_q.rate;

endmodule

// File: tb/tb_chirp_cfg_tx.sv
// Directed bench for chirp_cfg_tx with a dds_chirp-style ACK responder
// (3-flop REQ sync in clk_96, 3-flop ACK sync back) or a hand-driven ACK.
module tb_chirp_cfg_tx;
  import chirp_cfg_pkg::*;

`ifdef CFG_TIMEOUT_EN
  localparam int unsigned TB_TMO = 16;
`else
  localparam int unsigned TB_TMO = 1024;
`endif

  logic              clk_125 = 1'b0;
  logic              clk_96  = 1'b0;
  logic              reset_n = 1'b0;
  logic              load    = 1'b0;
  logic [FREQ_W-1:0] freq_in  = '0;
  logic [FREQ_W-1:0] dfreq_in = '0;
  logic [RATE_W-1:0] rate_in  = '0;
  logic              REQ;
  logic              ACK;
  logic [FREQ_W-1:0] DDS_freq;
  logic [FREQ_W-1:0] DDS_delta_freq;
  logic [RATE_W-1:0] DDS_delta_rate;
  logic              busy, pending, done, overrun, err;

  logic [2:0] req_s = '0;
  logic       ack_r = 1'b0;
  logic [2:0] ack_s = '0;
  logic       use_man = 1'b0;
  logic       ack_man = 1'b0;

  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int err_cnt = 0;

  always #4 clk_125 = ~clk_125;
  always #5 clk_96  = ~clk_96;

  always @(posedge clk_96) begin
    req_s <= {req_s[1:0], REQ};
    ack_r <= req_s[2];
  end
  always @(posedge clk_125) ack_s <= {ack_s[1:0], ack_r};
  assign ACK = use_man ? ack_man : ack_s[2];

  always @(negedge clk_125) begin
    if (done)    done_cnt++;
    if (overrun) ovr_cnt++;
    if (err)     err_cnt++;
  end

  chirp_cfg_tx #(.TIMEOUT_CYC(TB_TMO)) dut (
    .clk_125        (clk_125),
    .reset_n        (reset_n),
    .load           (load),
    .freq_in        (freq_in),
    .dfreq_in       (dfreq_in),
    .rate_in        (rate_in),
    .REQ            (REQ),
    .ACK            (ACK),
    .DDS_freq       (DDS_freq),
    .DDS_delta_freq (DDS_delta_freq),
    .DDS_delta_rate (DDS_delta_rate),
    .busy           (busy),
    .pending        (pending),
    .done           (done),
    .overrun        (overrun),
    .err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [FREQ_W-1:0] f,
                       input logic [FREQ_W-1:0] df, input logic [RATE_W-1:0] r);
    load     = ld;
    freq_in  = f;
    dfreq_in = df;
    rate_in  = r;
  endtask

  task automatic wait_req(input logic v, input string tag);
    int n = 0;
    while (REQ !== v && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(REQ), 64'(v));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_req", 64'(REQ), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_pend", 64'(pending), 0);
    chk("rst_freq", 64'(DDS_freq), 0);
    chk("rst_err", 64'(err), 0);
    reset_n = 1'b1;
    tick();

    // 1: single write
    drive(1'b1, 48'h2800_0000_0000, 48'd1000, 32'd96);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("t1_req", 64'(REQ), 1);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_freq", 64'(DDS_freq), 64'h2800_0000_0000);
    chk("t1_dfreq", 64'(DDS_delta_freq), 64'd1000);
    chk("t1_rate", 64'(DDS_delta_rate), 64'd96);
    wait_req(1'b0, "t1_req_fall");
    wait_done("t1_done");
    chk("t1_busy_end", 64'(busy), 0);
    chk("t1_hold", 64'(DDS_freq), 64'h2800_0000_0000);

    // 2: queued write during WAIT_ACK_HI
    drive(1'b1, 48'd3, 48'd1, 32'd1);
    tick();
    drive(1'b1, 48'd5, 48'd2, 32'd2);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("t2_pend", 64'(pending), 1);
    chk("t2_stable", 64'(DDS_freq), 64'd3);
    wait_done("t2_done_a");
    chk("t2_pend_idle", 64'(pending), 1);
    tick();
    chk("t2_relaunch", 64'(REQ), 1);
    chk("t2_freq", 64'(DDS_freq), 64'd5);
    chk("t2_pend_clr", 64'(pending), 0);
    wait_done("t2_done_b");
    chk("t2_no_ovr", 64'(ovr_cnt), 0);

    // 3: overwrite of queued entry
    drive(1'b1, 48'd6, 48'd0, 32'd0);
    tick();
    drive(1'b1, 48'd7, 48'd0, 32'd0);
    tick();
    chk("t3_ovr_first", 64'(overrun), 0);
    drive(1'b1, 48'd9, 48'd0, 32'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("t3_ovr_second", 64'(overrun), 1);
    wait_done("t3_done_a");
    tick();
    chk("t3_freq", 64'(DDS_freq), 64'd9);
    wait_done("t3_done_b");
    chk("t3_ovr_cnt", 64'(ovr_cnt), 1);

    // 4: load on the completion edge, hand-driven ACK
    use_man = 1'b1;
    ack_man = 1'b0;
    drive(1'b1, 48'd11, 48'd0, 32'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("t4_req", 64'(REQ), 1);
    ack_man = 1'b1;
    tick();
    chk("t4_req_fall", 64'(REQ), 0);
    ack_man = 1'b0;
    drive(1'b1, 48'd13, 48'd0, 32'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("t4_done", 64'(done), 1);
    chk("t4_pend", 64'(pending), 1);
    chk("t4_busy", 64'(busy), 0);
    tick();
    chk("t4_req2", 64'(REQ), 1);
    chk("t4_freq", 64'(DDS_freq), 64'd13);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    tick();
    chk("t4_done2", 64'(done), 1);

    // stale ACK already high on entry to WAIT_ACK_HI
    ack_man = 1'b1;
    drive(1'b1, 48'd15, 48'd0, 32'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("stale_req", 64'(REQ), 1);
    tick();
    chk("stale_fall", 64'(REQ), 0);
    ack_man = 1'b0;
    tick();
    chk("stale_done", 64'(done), 1);
    use_man = 1'b0;
    repeat (2) tick();

    // 5: reset mid-handshake
    drive(1'b1, 48'd21, 48'd0, 32'd0);
    tick();
    drive(1'b1, 48'd23, 48'd0, 32'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("t5_pre_pend", 64'(pending), 1);
    reset_n = 1'b0;
    #1;
    chk("t5_req", 64'(REQ), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_pend", 64'(pending), 0);
    chk("t5_freq", 64'(DDS_freq), 0);
    repeat (20) tick();
    reset_n = 1'b1;
    tick();
    drive(1'b1, 48'd25, 48'd0, 32'd0);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("t5_relaunch", 64'(REQ), 1);
    wait_done("t5_done");
    chk("t5_freq_end", 64'(DDS_freq), 64'd25);

`ifdef CFG_TIMEOUT_EN
    // 6: timeout with ACK held low
    use_man = 1'b1;
    ack_man = 1'b0;
    repeat (2) tick();
    begin
      int d0;
      d0 = done_cnt;
      drive(1'b1, 48'd31, 48'd0, 32'd0);
      tick();
      drive(1'b0, '0, '0, '0);
      chk("t6_req", 64'(REQ), 1);
      repeat (15) tick();
      chk("t6_err_early", 64'(err), 0);
      tick();
      chk("t6_err", 64'(err), 1);
      chk("t6_req_fall", 64'(REQ), 0);
      tick();
      chk("t6_idle", 64'(busy), 0);
      tick();
      chk("t6_no_done", 64'(done_cnt - d0), 0);
      chk("t6_err_cnt", 64'(err_cnt), 1);
    end
`else
    chk("no_err", 64'(err_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/chirp_cfg_tx.md
Name: chirp_cfg_tx

Overview:
- Source-side (clk_125) initiator of the 4-phase REQ/ACK handshake that moves chirp configuration (start frequency, frequency step, step rate) into the 96 MHz DDS chirp generator.
- Captures a configuration write from the control logic and drives the configuration buses.
- Holds the buses stable for the whole handshake.
- Provides a one-deep pending buffer, so a write that arrives mid-handshake is queued and not lost.

Parameters:
- FREQ_W, 48, width of DDS_freq and DDS_delta_freq.
- RATE_W, 32, width of DDS_delta_rate.
- TIMEOUT_CYC, 1024, clk_125 cycles allowed per handshake phase (used only with CFG_TIMEOUT_EN).

Ports:
- clk_125  in  1  clock; the sole clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle write strobe for a new configuration.
- freq_in  in  FREQ_W  start phase increment.
- dfreq_in  in  FREQ_W  phase increment step.
- rate_in  in  RATE_W  cycles between steps.
- REQ  out  1  handshake request to the 96 MHz domain.
- ACK  in  1  handshake acknowledge; already synchronized into clk_125 by the receiver.
- DDS_freq  out  FREQ_W  registered configuration bus.
- DDS_delta_freq  out  FREQ_W  registered configuration bus.
- DDS_delta_rate  out  RATE_W  registered configuration bus.
- busy  out  1  high while the FSM is not IDLE.
- pending  out  1  the pending buffer holds a queued configuration.
- done  out  1  one-cycle pulse when a handshake completes.
- overrun  out  1  one-cycle pulse when a queued configuration is overwritten and discarded.
- err  out  1  one-cycle pulse when a timeout abort occurs.

Behaviour:
- Reset (asynchronous, active-low): FSM=IDLE. REQ, busy, pending, done, overrun, err all 0. All three data buses 0. Pending buffer cleared.
- FSM states: IDLE, WAIT_ACK_HI, WAIT_ACK_LO.
- IDLE, launch: if load=1 or pending=1, on the same edge:
  - load the data buses;
  - set REQ=1;
  - go to WAIT_ACK_HI.
- IDLE, launch source: load=1 takes priority over the pending buffer.
  - If load=1 and pending=1 together: buses take freq_in/dfreq_in/rate_in, the pending buffer is cleared, overrun pulses.
  - Latency from load to REQ=1 is 1 cycle.
- WAIT_ACK_HI: when ACK=1, set REQ=0 and go to WAIT_ACK_LO.
- WAIT_ACK_LO: when ACK=0, pulse done and go to IDLE. A queued entry launches on the next cycle.
- Minimum transaction time is 2 IDLE-to-IDLE transitions plus the receiver's synchronizer round trip.
- Data buses change only on a launch edge. They are stable from REQ rise until ACK is seen low.
- load while busy=1:
  - the word is written into the pending buffer and pending is set;
  - if pending was already 1, the old entry is overwritten and overrun pulses;
  - the newest word always wins.
- load on the same cycle as WAIT_ACK_LO completion: the word is written to pending and launches from IDLE on the next cycle (no loss).
- ACK already high on entry to WAIT_ACK_HI (stale): treated as a valid acknowledge. The protocol guarantees ACK returns low before completion.
- reset_n asserted mid-handshake: REQ drops immediately and the pending entry is lost. The receiver recovers because REQ=0 drives its ACK low.
- Output timing: done, overrun and err are single-cycle pulses, registered. REQ and busy are registered; no combinational paths from inputs to outputs.

Optional Feature:
- Macro: CFG_TIMEOUT_EN.
- With the macro defined:
  - A clog2(TIMEOUT_CYC+1)-bit counter clears on every state entry and increments in WAIT_ACK_HI and WAIT_ACK_LO.
  - When it reaches TIMEOUT_CYC in WAIT_ACK_HI: err pulses, REQ goes to 0, FSM goes to WAIT_ACK_LO.
  - When it reaches TIMEOUT_CYC in WAIT_ACK_LO: err pulses, FSM goes to IDLE without a done pulse.
- Without the macro: the block waits indefinitely, err is tied 0, and no counter is present.

Decomposition:
- Package chirp_cfg_pkg holds:
  - FREQ_W and RATE_W;
  - typedef chirp_cfg_t, a struct of freq, dfreq and rate;
  - enum cfg_tx_state_t {IDLE, WAIT_ACK_HI, WAIT_ACK_LO}.
- The pending buffer and data registers use chirp_cfg_t.
- No sub-module; a single flat module is sufficient.
- The bench uses the dds_chirp handshake as the ACK responder: 3-flop REQ synchronizer, 3-flop ACK synchronizer.

Test Plan:
1. Single write: release reset; load with freq_in=48'h2800_0000_0000, dfreq_in=48'd1000, rate_in=32'd96 -> REQ=1 one cycle later with buses equal to inputs; responder ACK -> REQ=0; ACK low -> done pulse, busy=0; buses hold their values.
2. Queued write: during WAIT_ACK_HI, load freq_in=48'd5 -> pending=1; after done, REQ rises again 1 cycle after IDLE with DDS_freq=5; pending=0; overrun never pulses.
3. Overwrite: two loads while busy (values 7 then 9) -> overrun pulses on the second; next transaction carries 9.
4. Simultaneous completion and load: load coincides with the ACK-low cycle -> no loss; value is sent next; done and the new REQ are separated by 1 IDLE cycle.
5. Reset mid-handshake: assert reset_n=0 in WAIT_ACK_HI -> REQ, busy, pending and buses are 0 immediately; after release, a new load completes normally.
6. CFG_TIMEOUT_EN with TIMEOUT_CYC=16, responder ACK held 0 -> err pulses 16 cycles after REQ rises; REQ falls; FSM returns to IDLE; no done pulse.
